arp_rx: RTL and testbench

//  Consumes the Ethernet payload stream from the MAC receive stage and parses ARP

---
 rtl/arp_rx.sv | 146 ++++++++++++++
 tb/tb_arp_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/arp_rx.sv
// ARP receive parser: qualifies ARP frames from the MAC payload stream, checks the
// fixed header fields and target IP, and reports the sender once the FCS verdict arrives.
module arp_rx #(
    parameter int          DATA_WIDTH = 8,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A80102
) (
    input  logic                  i_sys_clk,
    input  logic                  i_rstn,
    input  logic                  i_new_packet_en,
    input  logic [DATA_WIDTH-1:0] i_packet_data,
    input  logic [15:0]           i_eth_type,
    input  logic                  i_bad_packet_en,
    input  logic                  i_bad_packet,
    output logic                  o_arp_rx_busy,
    output logic                  o_arp_valid,
    output logic                  o_arp_drop,
    output logic [15:0]           o_arp_opcode,
    output logic [47:0]           o_sender_mac,
    output logic [31:0]           o_sender_ip
);

    typedef enum logic [1:0] {IDLE, RECV, PAD, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  byte_cnt, cnt_nxt;
    logic        err, err_nxt;
    logic        fcs_bad;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;

    logic        consume;
    logic        finish;
    logic        last_byte;
    logic        byte_err;
    logic        opcode_ok;
    logic        accept_ok;
    logic [4:0]  off;

    // Byte offset and per-byte header check for the byte presented this cycle.
    always_comb begin
        consume   = i_new_packet_en &&
                    ((state == IDLE && i_eth_type == 16'h0806) || state == RECV);
        off       = (state == IDLE) ? 5'd0 : byte_cnt;
        last_byte = consume && (off == 5'd27);
        finish    = i_bad_packet_en && (state == RECV || state == PAD);
        byte_err  = 1'b0;
        case (off)
            5'd0:    byte_err = (i_packet_data != 8'h00);
            5'd1:    byte_err = (i_packet_data != 8'h01);
            5'd2:    byte_err = (i_packet_data != 8'h08);
            5'd3:    byte_err = (i_packet_data != 8'h00);
            5'd4:    byte_err = (i_packet_data != 8'h06);
            5'd5:    byte_err = (i_packet_data != 8'h04);
            5'd24:   byte_err = (i_packet_data != LOCAL_IP[31:24]);
            5'd25:   byte_err = (i_packet_data != LOCAL_IP[23:16]);
            5'd26:   byte_err = (i_packet_data != LOCAL_IP[15:8]);
            5'd27:   byte_err = (i_packet_data != LOCAL_IP[7:0]);
            default: byte_err = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = byte_cnt;
        err_nxt       = err;
        o_arp_rx_busy = (state != IDLE) || consume;
        opcode_ok     = (oper == 16'd1) || (oper == 16'd2);
        o_arp_valid   = 1'b0;
        o_arp_drop    = 1'b0;
        case (state)
            IDLE: begin
                if (consume) begin
                    state_nxt = RECV;
                    cnt_nxt   = 5'd1;
                    err_nxt   = byte_err;
                end
            end
            RECV: begin
                if (consume) begin
                    cnt_nxt = byte_cnt + 5'd1;
                    err_nxt = err | byte_err;
                    if (last_byte) state_nxt = PAD;
                end
                // A verdict before offset 27 has been consumed means a truncated frame.
                if (i_bad_packet_en) begin
                    state_nxt = DONE;
                    if (!last_byte) err_nxt = 1'b1;
                end
            end
            PAD: begin
                if (i_bad_packet_en) state_nxt = DONE;
            end
            DONE: begin
                state_nxt   = IDLE;
                cnt_nxt     = 5'd0;
                o_arp_valid = !err && !fcs_bad && opcode_ok;
                o_arp_drop  = !(!err && !fcs_bad && opcode_ok);
            end
            default: state_nxt = IDLE;
        endcase
        // Same verdict as o_arp_valid in DONE, evaluated one cycle early for the result latch.
        accept_ok = !err_nxt && !i_bad_packet && opcode_ok;
    end

    always_ff @(posedge i_sys_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= IDLE;
            byte_cnt <= 5'd0;
            err      <= 1'b0;
            fcs_bad  <= 1'b0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= cnt_nxt;
            err      <= err_nxt;
            if (finish) fcs_bad <= i_bad_packet;
        end
    end

    // Working field latches, big-endian shift-in.
    always_ff @(posedge i_sys_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            oper <= 16'd0;
            sha  <= 48'd0;
            spa  <= 32'd0;
        end else if (consume) begin
            if (off == 5'd6 || off == 5'd7)   oper <= {oper[7:0], i_packet_data};
            if (off >= 5'd8 && off <= 5'd13)  sha  <= {sha[39:0], i_packet_data};
            if (off >= 5'd14 && off <= 5'd17) spa  <= {spa[23:0], i_packet_data};
        end
    end

    // Reported fields change only for an accepted frame, visible alongside o_arp_valid.
    always_ff @(posedge i_sys_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_arp_opcode <= 16'd0;
            o_sender_mac <= 48'd0;
            o_sender_ip  <= 32'd0;
        end else if (finish && accept_ok) begin
            o_arp_opcode <= oper;
            o_sender_mac <= sha;
            o_sender_ip  <= spa;
        end
    end

endmodule

// File: tb/tb_arp_rx.sv
// Directed bench for arp_rx: drivers push expected result pulses into a queue and an
// independent monitor pops and compares whenever valid or drop fires.
module tb_arp_rx;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        new_en = 1'b0;
    logic [7:0]  data = 8'h00;
    logic [15:0] eth = 16'h0000;
    logic        bad_en = 1'b0;
    logic        bad = 1'b0;
    logic        busy, valid, drop;
    logic [15:0] opcode;
    logic [47:0] mac;
    logic [31:0] ip;

    localparam int EW = 97;
    logic [EW-1:0] exp_q[$];
    logic [7:0]    frm[0:63];

    logic [15:0] m_op  = 16'd0;
    logic [47:0] m_mac = 48'd0;
    logic [31:0] m_ip  = 32'd0;

    int checks = 0;
    int passes = 0;

    arp_rx dut (
        .i_sys_clk      (clk),
        .i_rstn         (rstn),
        .i_new_packet_en(new_en),
        .i_packet_data  (data),
        .i_eth_type     (eth),
        .i_bad_packet_en(bad_en),
        .i_bad_packet   (bad),
        .o_arp_rx_busy  (busy),
        .o_arp_valid    (valid),
        .o_arp_drop     (drop),
        .o_arp_opcode   (opcode),
        .o_sender_mac   (mac),
        .o_sender_ip    (ip)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Monitor: every result pulse must match the head of the expected queue.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rstn && (valid || drop)) begin
            check("pulse_exclusive", {63'd0, valid & drop}, 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_pulse: got valid=%0b drop=%0b expected none", valid, drop);
            end else begin
                e = exp_q.pop_front();
                check("pulse_valid", {63'd0, valid}, {63'd0, e[96]});
                check("pulse_drop", {63'd0, drop}, {63'd0, ~e[96]});
                check("opcode", {48'd0, opcode}, {48'd0, e[95:80]});
                check("sender_mac", {16'd0, mac}, {16'd0, e[79:32]});
                check("sender_ip", {32'd0, ip}, {32'd0, e[31:0]});
            end
        end
    end

    task automatic expect_result(input bit ok, input logic [15:0] op,
                                 input logic [47:0] sha, input logic [31:0] spa);
        if (ok) begin
            m_op  = op;
            m_mac = sha;
            m_ip  = spa;
        end
        exp_q.push_back({ok, m_op, m_mac, m_ip});
    endtask

    task automatic build_arp(input logic [15:0] op, input logic [7:0] hlen,
                             input logic [47:0] sha, input logic [31:0] spa,
                             input logic [31:0] tpa);
        logic [7:0] hdr[0:5];
        hdr = '{8'h00, 8'h01, 8'h08, 8'h00, hlen, 8'h04};
        for (int i = 0; i < 64; i++) frm[i] = 8'h00;
        for (int i = 0; i < 6; i++) frm[i] = hdr[i];
        frm[6] = op[15:8];
        frm[7] = op[7:0];
        for (int i = 0; i < 6; i++) frm[8 + i] = sha[47 - 8*i -: 8];
        for (int i = 0; i < 4; i++) frm[14 + i] = spa[31 - 8*i -: 8];
        for (int i = 0; i < 4; i++) frm[24 + i] = tpa[31 - 8*i -: 8];
        for (int i = 28; i < 46; i++) frm[i] = 8'hA5;
    endtask

    // Drives n payload bytes then the FCS verdict (or together with the last byte).
    task automatic send(input logic [15:0] typ, input int n, input bit fcs_bad,
                        input bit merge_last, input bit is_arp);
        for (int i = 0; i < n; i++) begin
            eth    = typ;
            data   = frm[i];
            new_en = 1'b1;
            if (merge_last && i == n - 1) begin
                bad_en = 1'b1;
                bad    = fcs_bad;
            end
            #1;
            check("busy_in_frame", {63'd0, busy}, {63'd0, is_arp});
            @(posedge clk);
            #1;
            new_en = 1'b0;
            bad_en = 1'b0;
        end
        if (!merge_last) begin
            bad_en = 1'b1;
            bad    = fcs_bad;
            @(posedge clk);
            #1;
            bad_en = 1'b0;
        end
        check("pulse_latency", {63'd0, valid | drop}, {63'd0, is_arp});
        check("busy_done", {63'd0, busy}, {63'd0, is_arp});
        @(posedge clk);
        #1;
        check("busy_after_done", {63'd0, busy}, 64'd0);
        check("pulse_one_cycle", {63'd0, valid | drop}, 64'd0);
        bad = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_valid", {63'd0, valid}, 64'd0);
        check("reset_drop", {63'd0, drop}, 64'd0);
        check("reset_fields", {opcode, mac}, 64'd0);
        check("reset_ip", {32'd0, ip}, 64'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Good request
        build_arp(16'd1, 8'd6, 48'h001122334455, 32'hC0A80101, 32'hC0A80102);
        expect_result(1'b1, 16'd1, 48'h001122334455, 32'hC0A80101);
        send(16'h0806, 46, 1'b0, 1'b0, 1'b1);

        // Same frame, FCS error: fields must keep the previous values
        expect_result(1'b0, 16'd0, 48'd0, 32'd0);
        send(16'h0806, 46, 1'b1, 1'b0, 1'b1);

        // Foreign target IP, bad opcode, wrong HLEN
        build_arp(16'd2, 8'd6, 48'hAABBCCDDEEFF, 32'hC0A80107, 32'hC0A80199);
        expect_result(1'b0, 16'd0, 48'd0, 32'd0);
        send(16'h0806, 46, 1'b0, 1'b0, 1'b1);
        build_arp(16'd3, 8'd6, 48'hAABBCCDDEEFF, 32'hC0A80107, 32'hC0A80102);
        expect_result(1'b0, 16'd0, 48'd0, 32'd0);
        send(16'h0806, 46, 1'b0, 1'b0, 1'b1);
        build_arp(16'd2, 8'd8, 48'hAABBCCDDEEFF, 32'hC0A80107, 32'hC0A80102);
        expect_result(1'b0, 16'd0, 48'd0, 32'd0);
        send(16'h0806, 46, 1'b0, 1'b0, 1'b1);

        // Truncated after 20 bytes
        build_arp(16'd1, 8'd6, 48'h001122334455, 32'hC0A80101, 32'hC0A80102);
        expect_result(1'b0, 16'd0, 48'd0, 32'd0);
        send(16'h0806, 20, 1'b0, 1'b0, 1'b1);

        // IPv4 frame: nothing happens
        send(16'h0800, 46, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of an ARP frame
        for (int i = 0; i < 12; i++) begin
            eth    = 16'h0806;
            data   = frm[i];
            new_en = 1'b1;
            @(posedge clk);
            #1;
        end
        new_en = 1'b0;
        rstn   = 1'b0;
        #1;
        check("midreset_busy", {63'd0, busy}, 64'd0);
        check("midreset_pulses", {62'd0, valid, drop}, 64'd0);
        check("midreset_fields", {opcode, mac}, 64'd0);
        check("midreset_ip", {32'd0, ip}, 64'd0);
        m_op  = 16'd0;
        m_mac = 48'd0;
        m_ip  = 32'd0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Good reply after reset
        build_arp(16'd2, 8'd6, 48'h0A0B0C0D0E0F, 32'hC0A80105, 32'hC0A80102);
        expect_result(1'b1, 16'd2, 48'h0A0B0C0D0E0F, 32'hC0A80105);
        send(16'h0806, 46, 1'b0, 1'b0, 1'b1);

        // Byte 27 together with the verdict counts as complete
        build_arp(16'd1, 8'd6, 48'h665544332211, 32'hC0A80123, 32'hC0A80102);
        expect_result(1'b1, 16'd1, 48'h665544332211, 32'hC0A80123);
        send(16'h0806, 28, 1'b0, 1'b1, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
